fnd_scan_driver: RTL and testbench

FND_SCAN_DRIVER -- requirements
Module: fnd_scan_driver

---
 rtl/fnd_scan_driver.sv | 118 +++++++++++
 tb/tb_fnd_scan_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: multiplexed 7-segment scanner; o_font/o_digit registered one cycle after idx moves; no backpressure (i_load always accepted).
// Optional leading-zero blanking is compiled in with macro FND_LZB_EN.
module fnd_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic                  i_blank,
  output logic [7:0]            o_font,
  output logic [DIGITS-1:0]     o_digit,
  output logic                  o_pending,
  output logic                  o_frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > 8 || DIV < 2) begin : g_param_err
    $error("fnd_scan_driver: DIGITS must be 1..8 and DIV at least 2");
  end

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   disp_val;
  logic [DIGITS-1:0]        disp_dp;
  logic [DIGITS-1:0][3:0]   shd_val;
  logic [DIGITS-1:0]        shd_dp;
  logic                     pending;
  logic                     tick;
  logic                     wrap;
  logic [6:0]               seg_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick      = (cnt == CW'(DIV - 1));
  assign wrap      = tick && (idx == IW'(DIGITS - 1));
  // Combinational so a client can align i_load with the wrap cycle itself.
  assign o_frame   = wrap && !i_reset;
  assign o_pending = pending;

`ifdef FND_LZB_EN
  logic [DIGITS-1:0] lz_mask;
  logic              lz_run;

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 never is.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lz_run     = lz_run && (disp_val[k] == 4'h0);
      lz_mask[k] = lz_run;
    end
  end

  always_comb begin
    seg_nxt = seg7(disp_val[idx]);
    if (lz_mask[idx]) seg_nxt = 7'h7F;
  end
`else
  always_comb begin
    seg_nxt = seg7(disp_val[idx]);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt      <= '0;
      idx      <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      shd_val  <= '0;
      shd_dp   <= '0;
      pending  <= 1'b0;
      o_font   <= 8'hFF;
      o_digit  <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= wrap ? '0 : idx + IW'(1);

      // Display only changes at the frame boundary so no frame mixes old and new data.
      if (wrap) begin
        disp_val <= i_load ? i_value : shd_val;
        disp_dp  <= i_load ? i_dp    : shd_dp;
        if (i_load) begin
          shd_val <= i_value;
          shd_dp  <= i_dp;
        end
        pending <= 1'b0;
      end else if (i_load) begin
        shd_val <= i_value;
        shd_dp  <= i_dp;
        pending <= 1'b1;
      end

      o_digit <= ~(DIGITS'(1) << idx);
      o_font  <= i_blank ? 8'hFF : {~disp_dp[idx], seg_nxt};
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver (DIGITS=4, DIV=4): directed steps plus random loads checked against a frame-level model.
module tb_fnd_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        i_reset, i_load, i_blank;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic [7:0]  o_font;
  logic [3:0]  o_digit;
  logic        o_pending, o_frame;

  int n_cmp = 0;
  int n_bad = 0;
  int j;  // clock edges since reset release

  logic [15:0] m_val, m_shd;
  logic [3:0]  m_dp, m_shd_dp;
  logic        m_pend;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  always #5 clk = ~clk;

  fnd_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_value  (i_value),
    .i_dp     (i_dp),
    .i_load   (i_load),
    .i_blank  (i_blank),
    .o_font   (o_font),
    .o_digit  (o_digit),
    .o_pending(o_pending),
    .o_frame  (o_frame)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, j);
    end
  endtask

  function automatic logic [7:0] exp_font(input int k);
    logic [3:0] n;
    logic [6:0] s;
    n = m_val[4*k +: 4];
    s = seg_tab[n];
`ifdef FND_LZB_EN
    if (k > 0 && (m_val >> (4 * k)) == 16'h0) s = 7'h7F;
`endif
    return {~m_dp[k], s};
  endfunction

  // One clock: drive inputs, check o_frame mid-cycle, then outputs after the edge.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic bl);
    int         k;
    logic       wr;
    logic [7:0] ef;
    logic [3:0] ed;
    i_load  = ld;
    i_value = v;
    i_dp    = d;
    i_blank = bl;
    wr = ((j + 1) % FRAME) == 0;
    k  = (j / DIV) % DIGITS;
    @(negedge clk);
    chk("frame", {7'd0, o_frame}, {7'd0, wr});
    ef = bl ? 8'hFF : exp_font(k);
    ed = ~(4'b0001 << k);
    if (wr) begin
      if (ld) begin
        m_val = v;
        m_dp  = d;
      end else if (m_pend) begin
        m_val = m_shd;
        m_dp  = m_shd_dp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_shd    = v;
      m_shd_dp = d;
      m_pend   = 1'b1;
    end
    @(posedge clk);
    #1;
    j++;
    chk("font", o_font, ef);
    chk("digit", {4'h0, o_digit}, {4'h0, ed});
    chk("pending", {7'd0, o_pending}, {7'd0, m_pend});
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic to_wrap_cycle();
    while (((j + 1) % FRAME) != 0) cyc(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  // Loads are presented during reset and must be ignored.
  task automatic do_reset(input int n);
    i_reset = 1'b1;
    i_load  = 1'b1;
    i_value = 16'($urandom);
    i_dp    = 4'($urandom);
    i_blank = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_frame", {7'd0, o_frame}, 8'h00);
      @(posedge clk);
      #1;
      chk("rst_font", o_font, 8'hFF);
      chk("rst_digit", {4'h0, o_digit}, 8'h0F);
      chk("rst_pending", {7'd0, o_pending}, 8'h00);
    end
    i_reset  = 1'b0;
    i_load   = 1'b0;
    j        = 0;
    m_val    = 16'h0;
    m_dp     = 4'h0;
    m_shd    = 16'h0;
    m_shd_dp = 4'h0;
    m_pend   = 1'b0;
  endtask

  initial begin
    logic        ld, bl;
    logic [15:0] v;
    logic [3:0]  d;

    j       = 0;
    i_reset = 1'b1;
    i_load  = 1'b0;
    i_blank = 1'b0;
    i_value = 16'h0;
    i_dp    = 4'h0;

    do_reset(2);
    idle(16);

    // Mid-frame load waits for the boundary, then a full frame of new data.
    idle(5);
    cyc(1'b1, 16'h1234, 4'b0100, 1'b0);
    chk("pend_set", {7'd0, o_pending}, 8'h01);
    to_wrap_cycle();
    idle(1);
    chk("pend_clr", {7'd0, o_pending}, 8'h00);
    idle(16);

    // Load coincident with the wrap cycle takes effect immediately.
    to_wrap_cycle();
    cyc(1'b1, 16'h0009, 4'h0, 1'b0);
    chk("coinc_pend", {7'd0, o_pending}, 8'h00);
    idle(16);

    // Blanking for 10 cycles.
    idle(3);
    repeat (10) cyc(1'b0, 16'h0, 4'h0, 1'b1);
    idle(6);

    // Non-decimal nibble and leading zeros.
    cyc(1'b1, 16'h00A5, 4'h0, 1'b0);
    to_wrap_cycle();
    idle(17);

    // Randomised loads, values and blanking.
    repeat (300) begin
      ld = ($urandom_range(0, 7) == 0);
      bl = ($urandom_range(0, 9) == 0);
      d  = 4'($urandom);
      for (int n = 0; n < 4; n++)
        v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cyc(ld, v, d, bl);
    end

    // Reset while a load is pending with idx=2.
    to_wrap_cycle();
    idle(1);
    while ((j % FRAME) != 8) cyc(1'b0, 16'h0, 4'h0, 1'b0);
    cyc(1'b1, 16'h5678, 4'b1111, 1'b0);
    chk("pend_mid", {7'd0, o_pending}, 8'h01);
    chk("digit_mid", {4'h0, o_digit}, 8'h0B);
    do_reset(1);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
